// File: rtl/usb_sync_eop_detector_pkg.sv
// Purpose : shared line-state encodings, error codes, framer state enum and
//           EOP decision record for the USB receive line-state framer.
// Ports   : none (package).
package usb_sync_eop_detector_pkg;

  // Sampled line state as produced by the sampler/DPLL.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  // Abort reasons reported alongside rx_err.
  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_SE1        = 2'b01,
    ERR_SE0_GLITCH = 2'b10,
    ERR_TIMEOUT    = 2'b11
  } err_code_e;

  // Framer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HUNT   = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_EOP    = 2'b11
  } rx_state_e;

  // Decision for the current symbol while in EOP. All-zero means another
  // SE0 arrived and the end-of-packet window is still open.
  typedef struct packed {
    logic eop_ok;  // J after a long enough SE0 run
    logic glitch;  // SE0 run too short, or K where J was expected
    logic se1;     // illegal SE1 inside EOP
  } eop_dec_t;

  // J and K carry data; SE0 and SE1 are line conditions.
  function automatic logic is_data(input logic [1:0] ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/usb_sync_eop_detector_if.sv
// Purpose : symbol input and framing status bundle between sampler side
//           (master) and the framer (slave).
// Ports   : sym_valid/line_state (master->slave); rx_active, sync_det,
//           eop_det, rx_err, err_code (slave->master).
interface usb_sync_eop_detector_if;
  logic       sym_valid;
  logic [1:0] line_state;
  logic       rx_active;
  logic       sync_det;
  logic       eop_det;
  logic       rx_err;
  logic [1:0] err_code;

  modport master (
    output sym_valid, line_state,
    input  rx_active, sync_det, eop_det, rx_err, err_code
  );

  modport slave (
    input  sym_valid, line_state,
    output rx_active, sync_det, eop_det, rx_err, err_code
  );
endinterface

// File: rtl/usb_eop_detector.sv
// Purpose : counts consecutive SE0 symbols of an end-of-packet and classifies
//           the symbol that terminates the run (valid EOP, glitch or SE1).
// Ports   : clk, reset (async active-low); i_start loads the run with the
//           first SE0, i_eval advances on a symbol in EOP; i_line_state is
//           the current symbol; o_dec is the combinational decision.
module usb_eop_detector
  import usb_sync_eop_detector_pkg::*;
#(
  parameter int EOP_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_eval,
  input  logic [1:0] i_line_state,
  output eop_dec_t   o_dec
);

  // Wide enough to hold EOP_LEN; the counter saturates at all-ones, which is
  // always >= EOP_LEN, so a long SE0 run never wraps back below threshold.
  localparam int              SE0_W   = (EOP_LEN < 2) ? 1 : $clog2(EOP_LEN + 1);
  localparam logic [SE0_W-1:0] SE0_MAX = '1;
  localparam logic [SE0_W-1:0] EOP_THR = SE0_W'(EOP_LEN);

  logic [SE0_W-1:0] r_se0;
  logic             w_long;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_se0 <= '0;
    end else if (i_start) begin
      // The SE0 that leaves ACTIVE is the first symbol of the run.
      r_se0 <= SE0_W'(1);
    end else if (i_eval) begin
      if (i_line_state == LS_SE0) begin
        if (r_se0 != SE0_MAX) r_se0 <= r_se0 + 1'b1;
      end else begin
        r_se0 <= '0;
      end
    end
  end

  assign w_long = (r_se0 >= EOP_THR);

  always_comb begin
    o_dec = '0;
    case (i_line_state)
      LS_J:    begin
        o_dec.eop_ok = w_long;
        o_dec.glitch = !w_long;
      end
      LS_K:    o_dec.glitch = 1'b1;
      LS_SE1:  o_dec.se1    = 1'b1;
      default: o_dec        = '0;
    endcase
  end

endmodule

// File: rtl/usb_sync_eop_detector.sv
// Purpose : USB receive line-state framer: hunts for SYNC, holds rx_active
//           over the packet body, closes on EOP and flags SE1 / SE0 glitch /
//           overlong-packet aborts. All outputs registered, one cycle after
//           the triggering sym_valid.
// Ports   : clk, reset (async active-low), bus (slave modport: sym_valid,
//           line_state in; rx_active, sync_det, eop_det, rx_err, err_code out).
module usb_sync_eop_detector
  import usb_sync_eop_detector_pkg::*;
#(
  parameter int MIN_ALT = 7,
  parameter int RUN_W   = 5,
  parameter int EOP_LEN = 2,
  parameter int MAX_PKT = 8192,
  parameter int PKT_W   = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  usb_sync_eop_detector_if.slave  bus
);

  localparam logic [RUN_W-1:0] MIN_ALT_C = RUN_W'(MIN_ALT);
  localparam logic [PKT_W-1:0] MAX_PKT_C = PKT_W'(MAX_PKT);

  rx_state_e        r_state;
  logic [RUN_W-1:0] r_run;
  logic [1:0]       r_last;
  logic [PKT_W-1:0] r_pkt;
  logic             r_rx_active;
  logic             r_sync_det;
  logic             r_eop_det;
  logic             r_rx_err;
  err_code_e        r_err_code;

  logic             w_vld;
  logic [1:0]       w_sym;
  logic             w_is_data;
  logic [RUN_W-1:0] w_run_inc;
  logic [PKT_W-1:0] w_pkt_inc;
  logic             w_timeout;
  logic             w_eop_start;
  logic             w_eop_eval;
  eop_dec_t         w_dec;

  assign w_vld     = bus.sym_valid;
  assign w_sym     = bus.line_state;
  assign w_is_data = is_data(w_sym);

  // Saturating increments: counters never wrap.
  assign w_run_inc = (r_run == '1) ? r_run : r_run + 1'b1;
  assign w_pkt_inc = (r_pkt == '1) ? r_pkt : r_pkt + 1'b1;

  // The data symbol that brings the body count to MAX_PKT aborts the packet
  // instead of being counted as ordinary payload.
  assign w_timeout = w_is_data && (w_pkt_inc >= MAX_PKT_C);

  assign w_eop_start = w_vld && (r_state == ST_ACTIVE) && (w_sym == LS_SE0);
  assign w_eop_eval  = w_vld && (r_state == ST_EOP);

  usb_eop_detector #(
    .EOP_LEN (EOP_LEN)
  ) u_eop (
    .clk          (clk),
    .reset        (reset),
    .i_start      (w_eop_start),
    .i_eval       (w_eop_eval),
    .i_line_state (w_sym),
    .o_dec        (w_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_run       <= '0;
      r_last      <= LS_SE0;
      r_pkt       <= '0;
      r_rx_active <= 1'b0;
      r_sync_det  <= 1'b0;
      r_eop_det   <= 1'b0;
      r_rx_err    <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      // Pulses last one cycle; rx_active and err_code hold.
      r_sync_det <= 1'b0;
      r_eop_det  <= 1'b0;
      r_rx_err   <= 1'b0;

      if (w_vld) begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_is_data) begin
              r_state <= ST_HUNT;
              r_run   <= RUN_W'(1);
              r_last  <= w_sym;
            end
          end

          ST_HUNT: begin
            if (!w_is_data) begin
              // SE0/SE1 during hunting is line noise, not a packet error.
              r_state <= ST_IDLE;
              r_run   <= '0;
            end else if (w_sym != r_last) begin
              r_run  <= w_run_inc;
              r_last <= w_sym;
            end else if ((w_sym == LS_K) && (r_run >= MIN_ALT_C)) begin
              // Second K of the K,K that closes SYNC.
              r_state     <= ST_ACTIVE;
              r_run       <= '0;
              r_pkt       <= '0;
              r_rx_active <= 1'b1;
              r_sync_det  <= 1'b1;
            end else begin
              // Repeated symbol breaks the alternation; it starts a new run.
              r_run <= RUN_W'(1);
            end
          end

          ST_ACTIVE: begin
            if (w_timeout) begin
              r_state     <= ST_IDLE;
              r_rx_active <= 1'b0;
              r_rx_err    <= 1'b1;
              r_err_code  <= ERR_TIMEOUT;
            end else if (w_is_data) begin
              r_pkt <= w_pkt_inc;
            end else if (w_sym == LS_SE0) begin
              r_state <= ST_EOP;
            end else begin
              r_state     <= ST_IDLE;
              r_rx_active <= 1'b0;
              r_rx_err    <= 1'b1;
              r_err_code  <= ERR_SE1;
            end
          end

          ST_EOP: begin
            if (w_dec.eop_ok) begin
              r_state     <= ST_IDLE;
              r_rx_active <= 1'b0;
              r_eop_det   <= 1'b1;
            end else if (w_dec.se1) begin
              r_state     <= ST_IDLE;
              r_rx_active <= 1'b0;
              r_rx_err    <= 1'b1;
              r_err_code  <= ERR_SE1;
            end else if (w_dec.glitch) begin
              r_state     <= ST_IDLE;
              r_rx_active <= 1'b0;
              r_rx_err    <= 1'b1;
              r_err_code  <= ERR_SE0_GLITCH;
            end
          end
        endcase
      end
    end
  end

  assign bus.rx_active = r_rx_active;
  assign bus.sync_det  = r_sync_det;
  assign bus.eop_det   = r_eop_det;
  assign bus.rx_err    = r_rx_err;
  assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_usb_sync_eop_detector.sv
// Randomised framing bench: every issued symbol pushes the reference model's
// expected outputs into a scoreboard; a monitor compares them one cycle later.
module tb_usb_sync_eop_detector;

  localparam int MIN_ALT = 7;
  localparam int EOP_LEN = 2;
  localparam int MAX_PKT = 16;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  typedef struct packed {
    logic       act;
    logic       sync;
    logic       eop;
    logic       err;
    logic [1:0] code;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_sync_eop_detector_if bus ();

  usb_sync_eop_detector #(
    .MIN_ALT (MIN_ALT),
    .RUN_W   (5),
    .EOP_LEN (EOP_LEN),
    .MAX_PKT (MAX_PKT),
    .PKT_W   (5)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 hunting, 2 in packet body, 3 in SE0 run of EOP
  int         m_mode;
  logic [1:0] hist[$];   // J/K symbols seen while hunting
  int         m_pkt;
  int         m_se0;
  logic       m_act;
  logic [1:0] m_code;

  function automatic void model_reset();
    m_mode = 0; m_pkt = 0; m_se0 = 0; m_act = 1'b0; m_code = 2'b00;
    hist.delete();
  endfunction

  // Length of the alternating J/K run at the end of the hunt history.
  function automatic int alt_len();
    int n = 1;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] != hist[i-1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic exp_t model_step(input logic [1:0] s);
    exp_t e = '0;
    logic data = (s == J) || (s == K);
    int   abort_code = 0;
    case (m_mode)
      0: if (data) begin m_mode = 1; hist.delete(); hist.push_back(s); end
      1: begin
        if (!data) m_mode = 0;
        else if (s == K && hist[hist.size()-1] == K && alt_len() >= MIN_ALT) begin
          m_mode = 2; m_act = 1'b1; e.sync = 1'b1; m_pkt = 0;
        end else begin
          hist.push_back(s);
          if (hist.size() > 64) void'(hist.pop_front());
        end
      end
      2: begin
        if (data) begin
          m_pkt++;
          if (m_pkt >= MAX_PKT) abort_code = 3;
        end else if (s == SE0) begin
          m_mode = 3; m_se0 = 1;
        end else abort_code = 1;
      end
      default: begin
        if (s == SE0) m_se0++;
        else if (s == J && m_se0 >= EOP_LEN) begin
          m_mode = 0; m_act = 1'b0; e.eop = 1'b1;
        end else abort_code = (s == SE1) ? 1 : 2;
      end
    endcase
    if (abort_code != 0) begin
      m_mode = 0; m_act = 1'b0; e.err = 1'b1; m_code = 2'(abort_code);
    end
    e.act  = m_act;
    e.code = m_code;
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  function automatic logic [5:0] dut_outs();
    return {bus.rx_active, bus.sync_det, bus.eop_det, bus.rx_err, bus.err_code};
  endfunction

  // Monitor: the cycle after an accepted symbol must show the scoreboard
  // head; idle cycles must show no pulses and held level/code.
  initial begin : monitor
    exp_t hold;
    exp_t e;
    logic v;
    hold = '0;
    forever begin
      @(posedge clk);
      v = bus.sym_valid && rst_n;
      @(negedge clk);
      if (!rst_n) begin
        hold = '0;
      end else if (v) begin
        if (sb.size() == 0) begin
          chk("scoreboard_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("symbol_response", 32'(dut_outs()), 32'(e));
          hold = e;
          hold.sync = 1'b0; hold.eop = 1'b0; hold.err = 1'b0;
        end
      end else begin
        chk("idle_hold", 32'(dut_outs()), 32'(hold));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_sym(input logic [1:0] s);
    exp_t e;
    int   gaps;
    gaps = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
    for (int g = 0; g < gaps; g++) begin
      @(posedge clk); #1;
      bus.sym_valid  = 1'b0;
      bus.line_state = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    e = model_step(s);
    sb.push_back(e);
    bus.sym_valid  = 1'b1;
    bus.line_state = s;
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sync(input int run_len);
    logic [1:0] s;
    s = (run_len % 2 == 1) ? K : J;
    for (int i = 0; i < run_len; i++) begin
      send_sym(s);
      s = (s == K) ? J : K;
    end
    send_sym(K);
  endtask

  task automatic mid_reset();
    go_idle(2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(dut_outs()), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    logic [1:0] t1[10];
    int n;
    bus.sym_valid  = 1'b0;
    bus.line_state = SE0;
    model_reset();
    #3 chk("reset_state", 32'(dut_outs()), 32'd0);
    #10 rst_n = 1'b1;

    // FS SYNC K J K J K J K K followed by data.
    t1 = '{K, J, K, J, K, J, K, K, J, J};
    foreach (t1[i]) send_sym(t1[i]);
    // Clean EOP closes it.
    send_sym(SE0); send_sym(SE0); send_sym(J);
    go_idle(2);

    for (int it = 0; it < 90; it++) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) send_sym(2'($urandom_range(0, 3)));
      send_sync($urandom_range(3, 12));
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) send_sym($urandom_range(0, 1) ? K : J);
      if (it % 15 == 7) begin
        mid_reset();
      end else begin
        n = $urandom_range(1, 3);
        case ($urandom_range(0, 5))
          0: begin repeat (n) send_sym(SE0); send_sym(J); end
          1: begin repeat (n) send_sym(SE0); send_sym(K); end
          2: send_sym(SE1);
          3: begin repeat (n) send_sym(SE0); send_sym(SE1); end
          4: begin send_sym(SE0); send_sym(J); end
          default: begin send_sym(SE0); send_sym(SE0); send_sym(J); end
        endcase
      end
      if ($urandom_range(0, 3) == 0) go_idle($urandom_range(1, 3));
    end

    go_idle(4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
